// File: rtl/abro_pkg.sv
// Shared constants for the ABRO input conditioner: the default debounce length,
// the channel index map and the debounce counter width helper.
package abro_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

    localparam int NUM_CH = 3;
    localparam int CH_A   = 0;
    localparam int CH_B   = 1;
    localparam int CH_R   = 2;

    // The counter must be able to hold values 0..DEBOUNCE_CYCLES.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/abro_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and a registered one-cycle pulse on each accepted rising edge.
module abro_debounce_ch
    import abro_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    logic          w_diff;
    logic          w_level_nxt;
    logic [CW-1:0] w_cnt_nxt;

    assign w_diff = r_sync2 ^ r_level;

    // Accepting on the cycle the count would reach DEBOUNCE_CYCLES keeps the
    // counter within 0..DEBOUNCE_CYCLES-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_cnt_nxt   = '0;
        w_level_nxt = r_level;
        if (w_diff) begin
            if (r_cnt == LP_LAST) begin
                w_level_nxt = ~r_level;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_level_q <= r_level;
            r_pulse   <= r_level & ~r_level_q;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/abro_input_conditioner.sv
// Debounces the A, B and R buttons into clean pulses for an ABRO controller and
// tracks whether both A and B have been seen since the last restart.
module abro_input_conditioner
    import abro_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic r_raw,
    output logic A,
    output logic B,
    output logic r_pulse,
    output logic ab_ready,
    output logic a_level,
    output logic b_level,
    output logic r_level
);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_pulse;

    logic r_a_seen;
    logic r_b_seen;
    logic r_ab_ready;

    assign w_raw[CH_A] = a_raw;
    assign w_raw[CH_B] = b_raw;
    assign w_raw[CH_R] = r_raw;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        abro_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (w_raw[g]),
            .o_level (w_level[g]),
            .o_pulse (w_pulse[g])
        );
    end

    // Flags act on the edge that samples the registered pulses; a restart pulse
    // on that edge overrides any coincident A or B pulse.
    always_ff @(posedge clk) begin
        if (reset || w_pulse[CH_R]) begin
            r_a_seen   <= 1'b0;
            r_b_seen   <= 1'b0;
            r_ab_ready <= 1'b0;
        end else begin
            r_a_seen   <= r_a_seen | w_pulse[CH_A];
            r_b_seen   <= r_b_seen | w_pulse[CH_B];
            r_ab_ready <= (r_a_seen | w_pulse[CH_A]) & (r_b_seen | w_pulse[CH_B]);
        end
    end

    assign A        = w_pulse[CH_A];
    assign B        = w_pulse[CH_B];
    assign r_pulse  = w_pulse[CH_R];
    assign ab_ready = r_ab_ready;
    assign a_level  = w_level[CH_A];
    assign b_level  = w_level[CH_B];
    assign r_level  = w_level[CH_R];

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Directed bench for abro_input_conditioner with DEBOUNCE_CYCLES = 4; expected
// edge positions are worked out by hand from the synchroniser/debounce latency.
module tb_abro_input_conditioner;

    logic clk;
    logic reset;
    logic a_raw, b_raw, r_raw;
    logic A, B, r_pulse, ab_ready, a_level, b_level, r_level;

    int n_total = 0;
    int n_bad   = 0;
    int n_a     = 0;
    int n_b     = 0;
    int n_r     = 0;
    int n_alvl  = 0;

    abro_input_conditioner #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_raw    (a_raw),
        .b_raw    (b_raw),
        .r_raw    (r_raw),
        .A        (A),
        .B        (B),
        .r_pulse  (r_pulse),
        .ab_ready (ab_ready),
        .a_level  (a_level),
        .b_level  (b_level),
        .r_level  (r_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (A)       n_a++;
        if (B)       n_b++;
        if (r_pulse) n_r++;
        if (a_level) n_alvl++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        reset = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        r_raw = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_A",        A,        0);
        check("rst_B",        B,        0);
        check("rst_r",        r_pulse,  0);
        check("rst_ready",    ab_ready, 0);
        check("rst_levels",   {a_level, b_level, r_level}, 0);
        reset = 1'b0;
        tick();
        check("post_rst_A",   A, 0);
        repeat (3) tick();

        // Single A press: level after edge k+5, pulse after edge k+6 only
        a_raw = 1'b1;
        repeat (5) tick();
        check("a_lvl_early",  a_level, 0);
        tick();
        check("a_lvl_rise",   a_level, 1);
        check("a_no_pulse_yet", A, 0);
        tick();
        check("a_pulse",      A, 1);
        check("a_only_ready", ab_ready, 0);
        tick();
        check("a_pulse_end",  A, 0);

        // B press ~20 cycles later sets ab_ready one cycle after B
        repeat (13) tick();
        n_b   = 0;
        b_raw = 1'b1;
        repeat (6) tick();
        check("b_no_pulse_yet", B, 0);
        tick();
        check("b_pulse",      B, 1);
        check("ready_lag",    ab_ready, 0);
        tick();
        check("ready_rise",   ab_ready, 1);
        check("b_pulse_end",  B, 0);
        repeat (10) tick();
        check("ready_hold",   ab_ready, 1);
        check("b_count",      n_b, 1);

        // R press clears ab_ready on the edge sampling r_pulse
        r_raw = 1'b1;
        repeat (6) tick();
        check("r_no_pulse_yet", r_pulse, 0);
        tick();
        check("r_pulse",      r_pulse, 1);
        tick();
        check("ready_clear",  ab_ready, 0);
        check("r_pulse_end",  r_pulse, 0);

        // Releasing all buttons: falling edges give no pulses
        n_a = 0; n_b = 0; n_r = 0;
        a_raw = 1'b0; b_raw = 1'b0; r_raw = 1'b0;
        repeat (12) tick();
        check("fall_pulses",  n_a + n_b + n_r, 0);
        check("fall_levels",  {a_level, b_level, r_level}, 0);

        // Glitch train: 3 high / 1 low, 40 cycles
        n_a = 0; n_alvl = 0;
        for (int i = 0; i < 10; i++) begin
            a_raw = 1'b1;
            repeat (3) tick();
            a_raw = 1'b0;
            tick();
        end
        repeat (6) tick();
        check("glitch_A",     n_a, 0);
        check("glitch_level", n_alvl, 0);

        // All three together: coincident pulses, R wins so ab_ready stays 0
        a_raw = 1'b1; b_raw = 1'b1; r_raw = 1'b1;
        repeat (6) tick();
        check("all_early",    {A, B, r_pulse}, 0);
        tick();
        check("all_coincide", {A, B, r_pulse}, 3'b111);
        tick();
        check("all_ready0",   ab_ready, 0);
        repeat (5) tick();
        check("all_ready0_hold", ab_ready, 0);
        a_raw = 1'b0; b_raw = 1'b0; r_raw = 1'b0;
        repeat (12) tick();

        // Reset with the A counter at 3, raw held through and after reset
        a_raw = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        n_a = 0;
        tick();
        check("mid_rst_A",    A, 0);
        check("mid_rst_lvl",  a_level, 0);
        tick();
        check("mid_rst_A2",   A, 0);
        check("mid_rst_cnt",  n_a, 0);
        reset = 1'b0;
        repeat (6) tick();
        check("requal_none",  n_a, 0);
        tick();
        check("requal_pulse", A, 1);
        tick();
        check("requal_end",   A, 0);
        check("requal_once",  n_a, 1);

        // Long hold, release, press again: exactly two A pulses overall
        repeat (100) tick();
        check("hold_no_repeat", n_a, 1);
        a_raw = 1'b0;
        repeat (20) tick();
        check("release_no_pulse", n_a, 1);
        check("release_level",  a_level, 0);
        a_raw = 1'b1;
        repeat (20) tick();
        check("second_press",   n_a, 2);
        check("second_level",   a_level, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/abro_input_conditioner.md
ABRO_INPUT_CONDITIONER -- requirements
Module: abro_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronised cycles a raw input must hold a new level before it is accepted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_raw  input  1  asynchronous, bouncy A button level.
REQ-005 b_raw  input  1  asynchronous, bouncy B button level.
REQ-006 r_raw  input  1  asynchronous, bouncy R (restart) button level.
REQ-007 A  output  1  one-cycle pulse on each accepted rising edge of a_raw; drives downstream ABRO input A.
REQ-008 B  output  1  one-cycle pulse on each accepted rising edge of b_raw; drives downstream ABRO input B.
REQ-009 r_pulse  output  1  one-cycle pulse on each accepted rising edge of r_raw.
REQ-010 ab_ready  output  1  level; high once both A and B pulses have occurred since the last r_pulse or reset.
REQ-011 a_level, b_level, r_level  output  1 each  current debounced levels.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchroniser before any other logic.
REQ-013 Per channel, a counter of width clog2(DEBOUNCE_CYCLES+1) SHALL increment each cycle the synchronised sample differs from the debounced level and SHALL clear to 0 in any cycle they are equal.
REQ-014 When the counter would reach DEBOUNCE_CYCLES, the debounced level SHALL toggle and the counter SHALL clear in the same edge; the counter SHALL never exceed DEBOUNCE_CYCLES.
REQ-015 Latency: raw held at 1 from edge k (first edge sampling it) SHALL produce the debounced level at edge k+1+DEBOUNCE_CYCLES and the pulse output registered high for exactly the cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-016 A raw excursion shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no level change and no pulse.
REQ-017 Falling edges of the debounced level SHALL produce no pulse; a new pulse requires a fresh accepted 0->1 transition.
REQ-018 ab_ready logic: two sticky flags a_seen, b_seen set by A and B pulses; ab_ready = a_seen AND b_seen, registered.
REQ-019 r_pulse SHALL clear a_seen, b_seen and ab_ready on the same edge; an A or B pulse in the same cycle as r_pulse SHALL be discarded (R wins).
REQ-020 A and B pulses in the same cycle SHALL set both flags; ab_ready high the following cycle.
REQ-021 A and B pulse outputs SHALL be passed through regardless of ab_ready (downstream decides).
REQ-022 Channels SHALL be fully independent; simultaneous events on all three SHALL each be handled per REQ-013..REQ-019.

Reset
REQ-023 reset high at an edge SHALL clear synchroniser flops, counters, debounced levels, sticky flags and all outputs to 0.
REQ-024 reset mid-debounce SHALL abandon the count; a raw input still high after reset release SHALL be re-qualified from zero and then pulse once.
REQ-025 No output SHALL pulse during the cycle reset is asserted or the first cycle after release.

Structure
REQ-026 Shared package abro_pkg SHALL hold DEBOUNCE_CYCLES default, counter-width function, and the channel index constants (CH_A, CH_B, CH_R).
REQ-027 One sub-module abro_debounce_ch (synchroniser + counter + level + rising-edge pulse) SHALL be instantiated three times; top holds sticky flags and ab_ready.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 a_raw 0->1 held from edge 10 -> a_level high after edge 15, A high exactly one cycle after edge 16, ab_ready stays 0.
REQ-029 a_raw glitch high for 3 cycles, repeated with 1-cycle lows for 40 cycles -> A, a_level never assert.
REQ-030 A pulse then B pulse 20 cycles later -> ab_ready rises one cycle after B and holds; subsequent r_raw press -> ab_ready clears on the r_pulse edge.
REQ-031 a_raw, b_raw, r_raw all raised at the same edge -> A, B, r_pulse coincide, ab_ready remains 0.
REQ-032 reset asserted at counter value 3 with a_raw held high, released 2 cycles later -> no A during reset; A fires exactly once 7 cycles after release.
REQ-033 a_raw held high 100 cycles then low then high -> exactly two A pulses, none on the falling edge.
